// File: rtl/edge_sync_pkg.sv
// Shared definitions for the req/ack edge-synchronizer pair (tx and rx sides).
// Holds the handshake state encoding and the default synchronizer depth.
package edge_sync_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ_HI   = 2'd1,
      ACK_WAIT = 2'd2
   } hs_state_e;

   localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Legal depth is 2 to 4 stages.
module sync_bit
   import edge_sync_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source side of a four-phase req/ack crossing: each input pulse becomes one
// full handshake; pulses arriving mid-handshake are counted and replayed.
module pulse_handshake_tx
   import edge_sync_pkg::*;
#(
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  logic             ack_async,
   input  logic             ovf_clr,
   output logic             req,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   hs_state_e        state;
   hs_state_e        state_nxt;
   logic             ack_s;
   logic             req_nxt;
   logic             done_nxt;
   logic             launch_cnt;
   logic             launch_new;
   logic             inc;
   logic             dec;
   logic [CNT_W-1:0] pending_nxt;
   logic             overflow_nxt;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ack_async),
      .q    (ack_s)
   );

   // A launch either consumes the incoming pulse directly or pulls one queued
   // event from the counter; queued events always go first.
   always_comb begin
      state_nxt  = state;
      done_nxt   = 1'b0;
      launch_cnt = 1'b0;
      launch_new = 1'b0;
      case (state)
         IDLE: begin
            if (pending != '0) begin
               launch_cnt = 1'b1;
               state_nxt  = REQ_HI;
            end else if (pulse_in) begin
               launch_new = 1'b1;
               state_nxt  = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               state_nxt = ACK_WAIT;
            end
         end
         ACK_WAIT: begin
            if (!ack_s) begin
               done_nxt = 1'b1;
               if (pending != '0) begin
                  launch_cnt = 1'b1;
                  state_nxt  = REQ_HI;
               end else if (pulse_in) begin
                  launch_new = 1'b1;
                  state_nxt  = REQ_HI;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      req_nxt = (state_nxt == REQ_HI);
   end

   always_comb begin
      inc          = pulse_in & ~launch_new;
      dec          = launch_cnt;
      pending_nxt  = pending;
      overflow_nxt = overflow & ~ovf_clr;
      if (inc && !dec) begin
         if (pending == PEND_MAX) begin
            overflow_nxt = 1'b1;
         end else begin
            pending_nxt = pending + 1'b1;
         end
      end else if (dec && !inc) begin
         pending_nxt = pending - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req      <= 1'b0;
         done     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         req      <= req_nxt;
         done     <= done_nxt;
         pending  <= pending_nxt;
         overflow <= overflow_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Self-checking bench for pulse_handshake_tx: a queue-count reference model
// plus directed scenarios, and a second narrow-counter instance for saturation.
module tb_pulse_handshake_tx;

   localparam int SYNC = 2;
   localparam int PMAX = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pulse_in = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       ack_async;
   logic       req, busy, done, overflow;
   logic [3:0] pending;

   logic       pulse2 = 1'b0;
   logic       ack2 = 1'b0;
   logic       clr2 = 1'b0;
   logic       req2, busy2, done2, ovf2;
   logic [1:0] pend2;

   int n_cmp = 0;
   int n_err = 0;

   // destination-side ack model
   logic ack_mdl = 1'b0;
   logic ack_man = 1'b0;
   bit   ack_stall = 1'b0;
   bit   ack_rand = 1'b0;
   int   dcnt = 0;
   int   delay_cur = 3;

   // reference model state
   int  q_m = 0;
   bit  ovf_m = 1'b0;
   int  rises = 0, dones = 0, accepted = 0, dropped = 0;
   bit  req_prev = 1'b0, done_prev = 1'b0;
   int  ack_low_cnt = 100;
   bit  p_cap = 1'b0, c_cap = 1'b0;

   always #5 clk = ~clk;

   assign ack_async = ack_stall ? ack_man : ack_mdl;

   pulse_handshake_tx #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .ack_async(ack_async),
      .ovf_clr(ovf_clr), .req(req), .busy(busy), .done(done),
      .pending(pending), .overflow(overflow)
   );

   pulse_handshake_tx #(.CNT_W(2), .SYNC_STAGES(SYNC)) dut_sat (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse2), .ack_async(ack2),
      .ovf_clr(clr2), .req(req2), .busy(busy2), .done(done2),
      .pending(pend2), .overflow(ovf2)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_mdl = 1'b0;
         dcnt = 0;
      end else begin
         #2;
         if (ack_stall) begin
            ack_mdl = ack_man;
            dcnt = 0;
         end else if (req !== ack_mdl) begin
            dcnt++;
            if (dcnt >= delay_cur) begin
               ack_mdl = req;
               dcnt = 0;
               delay_cur = ack_rand ? int'($urandom_range(1, 20)) : 3;
            end
         end else begin
            dcnt = 0;
         end
      end
   end

   always @(posedge clk) begin
      p_cap = pulse_in;
      c_cap = ovf_clr;
   end

   // Model: queued events = accepted - launched; a launch is a req rise.
   always @(negedge clk) begin
      int launch, nq;
      bit drop;
      if (!rst_n) begin
         q_m = 0; ovf_m = 0; rises = 0; dones = 0; accepted = 0; dropped = 0;
         req_prev = 0; done_prev = 0; ack_low_cnt = 100;
      end else begin
         if (ack_async === 1'b0) ack_low_cnt++;
         else ack_low_cnt = 0;
         launch = (req && !req_prev) ? 1 : 0;
         if (launch == 1) begin
            rises++;
            n_cmp++;
            if (ack_low_cnt < SYNC + 2) begin
               n_err++;
               $display("FAIL req_rise_ack_low: ack low for %0d samples, required >= %0d", ack_low_cnt, SYNC + 2);
            end
         end
         if (done) begin
            dones++;
            n_cmp++;
            if (done_prev) begin
               n_err++;
               $display("FAIL done_width: done high %0d consecutive cycles, required 1", 2);
            end
         end
         nq = q_m + int'(p_cap) - launch;
         drop = (nq > PMAX);
         if (drop) begin
            nq = PMAX;
            ovf_m = 1'b1;
            dropped++;
         end else if (c_cap) begin
            ovf_m = 1'b0;
         end
         if (p_cap && !drop) accepted++;
         q_m = nq;
         n_cmp++;
         if (pending !== q_m[3:0]) begin
            n_err++;
            $display("FAIL pending_model: got %0d, required %0d at %0t", pending, q_m, $time);
         end
         n_cmp++;
         if (overflow !== ovf_m) begin
            n_err++;
            $display("FAIL overflow_model: got %0b, required %0b at %0t", overflow, ovf_m, $time);
         end
         req_prev = req;
         done_prev = done;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; pulse_in = 0; ovf_clr = 0; pulse2 = 0; ack2 = 0; clr2 = 0;
      ack_stall = 0; ack_man = 0; ack_rand = 0; delay_cur = 3;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_quiet(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && !req && ack_async == 1'b0 && pending == 4'd0) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b, required 0", req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
      n_cmp++; if (pending !== 4'd0) begin n_err++; $display("FAIL reset_pending: got %0d, required 0", pending); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
      n_cmp++; if (pend2 !== 2'd0) begin n_err++; $display("FAIL reset_pend2: got %0d, required 0", pend2); end
      do_reset();
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      @(negedge clk); pulse_in = 1'b1;
      @(negedge clk); pulse_in = 1'b0;
      n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL single_req_rise: got %b, required 1", req); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b, required 1", busy); end
      wait_quiet(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: idle reached %0b, required 1", ok); end
      n_cmp++; if (rises != 1) begin n_err++; $display("FAIL single_rises: got %0d, required 1", rises); end
      n_cmp++; if (dones != 1) begin n_err++; $display("FAIL single_dones: got %0d, required 1", dones); end
   endtask

   task automatic test_burst();
      bit ok;
      int peak = 0;
      do_reset();
      @(negedge clk); pulse_in = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (int'(pending) > peak) peak = int'(pending);
      end
      pulse_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (int'(pending) > peak) peak = int'(pending);
      end
      wait_quiet(500, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_timeout: idle reached %0b, required 1", ok); end
      n_cmp++; if (peak != 4) begin n_err++; $display("FAIL burst_peak: got %0d, required 4", peak); end
      n_cmp++; if (rises != 5) begin n_err++; $display("FAIL burst_rises: got %0d, required 5", rises); end
      n_cmp++; if (dones != 5) begin n_err++; $display("FAIL burst_dones: got %0d, required 5", dones); end
   endtask

   task automatic test_simultaneous();
      bit ok, seen;
      do_reset();
      ack_stall = 1'b1; ack_man = 1'b0;
      @(negedge clk); pulse_in = 1'b1;
      repeat (3) @(negedge clk);
      pulse_in = 1'b0;
      n_cmp++; if (pending !== 4'd2) begin n_err++; $display("FAIL simul_setup_pending: got %0d, required 2", pending); end
      ack_man = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!req) begin seen = 1'b1; break; end
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL simul_req_fall: fall seen %0b, required 1", seen); end
      ack_man = 1'b0;
      repeat (SYNC) @(negedge clk);
      pulse_in = 1'b1;
      @(negedge clk);
      pulse_in = 1'b0;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL simul_done: got %b, required 1", done); end
      n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL simul_relaunch: got %b, required 1", req); end
      n_cmp++; if (pending !== 4'd2) begin n_err++; $display("FAIL simul_pending: got %0d, required 2", pending); end
      ack_stall = 1'b0;
      wait_quiet(500, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL simul_timeout: idle reached %0b, required 1", ok); end
      n_cmp++; if (rises != 4 || dones != 4) begin n_err++; $display("FAIL simul_counts: rises %0d dones %0d, required 4 and 4", rises, dones); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      ack_stall = 1'b1; ack_man = 1'b0;
      @(negedge clk); pulse_in = 1'b1;
      repeat (4) @(negedge clk);
      pulse_in = 1'b0;
      n_cmp++; if (req !== 1'b1 || pending !== 4'd3) begin n_err++; $display("FAIL rstmid_setup: req %b pending %0d, required 1 and 3", req, pending); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if ({req, busy, done, overflow} !== 4'b0000 || pending !== 4'd0) begin
         n_err++; $display("FAIL rstmid_clear: req %b busy %b done %b ovf %b pending %0d, required all 0", req, busy, done, overflow, pending);
      end
      ack_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      n_cmp++; if (rises != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_req: rises %0d busy %b, required 0 and 0", rises, busy); end
      @(negedge clk); pulse_in = 1'b1;
      @(negedge clk); pulse_in = 1'b0;
      wait_quiet(200, ok);
      n_cmp++; if (!ok || rises != 1) begin n_err++; $display("FAIL rstmid_new_event: ok %0b rises %0d, required 1 and 1", ok, rises); end
   endtask

   task automatic test_saturation();
      int r = 0, d = 0;
      bit prev;
      do_reset();
      @(negedge clk); pulse2 = 1'b1;
      repeat (6) @(negedge clk);
      pulse2 = 1'b0;
      n_cmp++; if (pend2 !== 2'd3) begin n_err++; $display("FAIL sat_pending: got %0d, required 3", pend2); end
      n_cmp++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL sat_overflow: got %b, required 1", ovf2); end
      prev = req2;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (req2 && !prev) r++;
         if (done2) d++;
         prev = req2;
         ack2 = req2;
         if (d == 4 && !busy2) break;
      end
      repeat (20) begin
         @(negedge clk);
         if (req2 && !prev) r++;
         if (done2) d++;
         prev = req2;
         ack2 = req2;
      end
      n_cmp++; if (d != 4) begin n_err++; $display("FAIL sat_dones: got %0d, required 4", d); end
      n_cmp++; if (r + 1 != 4) begin n_err++; $display("FAIL sat_handshakes: got %0d, required 4", r + 1); end
      n_cmp++; if (pend2 !== 2'd0 || ovf2 !== 1'b1) begin n_err++; $display("FAIL sat_drained: pending %0d ovf %b, required 0 and 1", pend2, ovf2); end
      clr2 = 1'b1;
      @(negedge clk); clr2 = 1'b0;
      n_cmp++; if (ovf2 !== 1'b0) begin n_err++; $display("FAIL sat_ovf_clr: got %b, required 0", ovf2); end
   endtask

   task automatic test_random();
      bit ok;
      do_reset();
      ack_rand = 1'b1;
      delay_cur = 5;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         pulse_in = ($urandom_range(0, 15) == 0);
         ovf_clr = ($urandom_range(0, 31) == 0);
      end
      @(negedge clk); pulse_in = 1'b0; ovf_clr = 1'b0;
      wait_quiet(3000, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_timeout: idle reached %0b, required 1", ok); end
      n_cmp++; if (rises != accepted) begin n_err++; $display("FAIL rand_rises: got %0d, required %0d", rises, accepted); end
      n_cmp++; if (dones != rises) begin n_err++; $display("FAIL rand_dones: got %0d, required %0d", dones, rises); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_simultaneous();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_handshake_tx.md
# pulse_handshake_tx

Source-side half of a four-phase req/ack crossing. Accepts single-cycle event pulses in its own clock domain and converts each event into one full req/ack handshake toward a destination domain. The destination domain synchronizes `req` and edge-detects it into a pulse. Events arriving while a handshake is in flight are counted and replayed in order, so no event is lost until the pending counter saturates.

## Interface
- `CNT_W`, default 4: width of the pending-event counter; max pending = 2^CNT_W − 1.
- `SYNC_STAGES`, default 2: flop stages on `ack_async` (legal range 2–4).
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `pulse_in` input 1: event strobe, one event per high cycle.
- `ack_async` input 1: level acknowledge from destination domain; asynchronous to `clk`.
- `ovf_clr` input 1: synchronous clear of `overflow`.
- `req` output 1: registered level request to destination domain, driven directly from a flop.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse when a handshake completes (synchronized ack falls).
- `pending` output CNT_W: events queued and not yet launched.
- `overflow` output 1: sticky flag, set when an event is dropped.

## Operation
- `ack_async` passes through a SYNC_STAGES flop chain to give `ack_s`. Only `ack_s` is used in the logic.
- The FSM has three states:
  - IDLE: `req` = 0.
    - `pulse_in` = 1 → REQ_HI.
    - `pending` > 0 → REQ_HI and decrement `pending`.
  - REQ_HI: `req` = 1.
    - `ack_s` = 1 → ACK_WAIT.
  - ACK_WAIT: `req` = 0.
    - `ack_s` = 0 → assert `done`.
    - If `pending` > 0: go to REQ_HI and decrement `pending`.
    - Otherwise, if `pulse_in` = 1: go to REQ_HI with no counter change.
    - Otherwise: go to IDLE.
- `pending` update rules:
  - Increment on `pulse_in` when the event is not consumed by a launch in that same cycle.
  - Decrement on a launch from the counter.
  - A launch from the counter in the same cycle as `pulse_in` leaves `pending` unchanged.
- Event order is FIFO by count. Events carry no payload.
- Saturation: `pulse_in` with `pending` = 2^CNT_W − 1 and no simultaneous launch drops the event and sets `overflow`.
- `overflow` clears only on `ovf_clr`. If a set and `ovf_clr` occur in the same cycle, the set wins.
- `req` never toggles while `ack_s` disagrees with the four-phase sequence. The next rise of `req` requires `ack_s` = 0 to have been observed.

## Timing
- Reset values: `req` = 0, `busy` = 0, `done` = 0, `pending` = 0, `overflow` = 0, state = IDLE, sync chain = 0.
- `pulse_in` in IDLE at edge t: `req` = 1 and `busy` = 1 after edge t+1.
- `ack_async` rising before edge a: `ack_s` = 1 after edge a+SYNC_STAGES−1. `req` falls one edge later.
- `ack_async` falling: `done` high for exactly one cycle, SYNC_STAGES+1 edges after the fall is first sampled.
- Back-to-back: the next `req` rise occurs in the same cycle `done` is high. `req` low time is therefore at least SYNC_STAGES+1 cycles, which the destination side must tolerate.
- Reset mid-handshake drops all state immediately (asynchronously), including queued events. The destination domain must be reset in the same reset sequence.
- `pulse_in` held high for N cycles counts as N events.

## Structure
- Put the state encoding (IDLE, REQ_HI, ACK_WAIT) in a shared package `edge_sync_pkg`. The package also holds the default `SYNC_STAGES` constant, shared with the receiver side.
- Make one sub-module, `sync_bit`: a parameterized SYNC_STAGES flop chain with async active-low reset. It is reusable by the receiver.
- The top level contains the FSM, the pending counter and the overflow logic.

## Test plan
- Single event: `pulse_in` for 1 cycle, ack model with 3-cycle delay each way → `req` 0→1→0 once, one `done`, `pending` stays 0, `overflow` stays 0.
- Burst: `pulse_in` held 5 cycles → `pending` peaks at 4, five `req` rises, five `done` pulses, final `pending` = 0.
- Saturation with CNT_W = 2: 6 consecutive pulses, ack stalled → `pending` = 3, `overflow` = 1. After ack release, exactly 4 handshakes. `ovf_clr` then clears `overflow`.
- Simultaneous: `pulse_in` coincides with the ACK_WAIT→REQ_HI relaunch while `pending` = 2 → `pending` stays 2 that cycle.
- Reset mid-handshake: assert `rst_n` = 0 while `req` = 1 and `pending` = 3 → all outputs 0 immediately, and no `req` after reset release until a new `pulse_in`.
- Protocol check: random `pulse_in`, random ack delays 1–20 cycles → assertions hold:
  - `req` rises only when `ack_s` = 0.
  - Count of `req` rises = accepted events.
  - `done` count = count of `req` rises.
